reg_bank_sched: RTL and testbench



---
 rtl/reg_bank_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/reg_bank_sched.sv | 164 ++++++++++++++++
 tb/tb_reg_bank_sched.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the DAL register-bank scheduler.
// The REG_BANK_SCHED_PRIO_EN option is handled in reg_bank_sched.
package reg_bank_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    SERVE = 1'b1
  } sched_state_e;

  localparam int WIDTH_DEF = 16;
  localparam int NREQ_DEF  = 4;
  localparam int DEPTH_DEF = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search starting at i_ptr, wrapping NREQ-1 -> 0.
// Pointer ownership and update stay in the parent.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  input  logic                    i_en,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_idx
);

  localparam int IW = $clog2(NREQ);

  logic          w_found;
  logic [IW:0]   w_pos;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_pos = {1'b0, i_ptr} + (IW+1)'(i);
      if (w_pos >= (IW+1)'(NREQ))
        w_pos = w_pos - (IW+1)'(NREQ);
      if (i_en && !w_found && i_req[w_pos[IW-1:0]]) begin
        w_found                = 1'b1;
        o_gnt[w_pos[IW-1:0]]   = 1'b1;
        o_idx                  = w_pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_bank_sched.sv
// Round-robin scheduler sharing a register bank, with reload sweep.
// `define REG_BANK_SCHED_PRIO_EN: requester 0 gets fixed top priority.
module reg_bank_sched
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int IW   = $clog2(NREQ)
) (
  input  logic               __clk,
  input  logic               __arst_n,
  input  logic [WIDTH-1:0]   __reset_value,
  input  logic               clr_i,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               busy_o
);

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic [AW-1:0]     r_idx;
  logic [AW-1:0]     w_idx_nxt;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     w_ptr_nxt;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              r_rsp_valid;
  logic [IW-1:0]     r_rsp_id;
  logic [WIDTH-1:0]  r_rsp_rdata;

  logic              w_en;
  logic              w_acc;
  logic              w_we;
  logic [NREQ-1:0]   w_arb_req;
  logic [NREQ-1:0]   w_arb_gnt;
  logic [IW-1:0]     w_arb_idx;
  logic [NREQ-1:0]   w_gnt;
  logic [IW-1:0]     w_win;
  logic [AW-1:0]     w_addr;
  logic [WIDTH-1:0]  w_wdata;

  assign w_en = (r_state == SERVE) && !clr_i;

`ifdef REG_BANK_SCHED_PRIO_EN
  localparam logic [IW-1:0] PTR_RST = IW'(1);

  // Requester 0 bypasses the ring; the ring covers 1..NREQ-1 only.
  assign w_arb_req = req_valid & ~NREQ'(1);

  always_comb begin
    w_gnt = w_arb_gnt;
    w_win = w_arb_idx;
    if (w_en && req_valid[0]) begin
      w_gnt = NREQ'(1);
      w_win = '0;
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_acc && (w_win != '0))
      w_ptr_nxt = (w_win == IW'(NREQ-1)) ? IW'(1)
                                         : w_win + 1'b1;
  end
`else
  localparam logic [IW-1:0] PTR_RST = '0;

  assign w_arb_req = req_valid;
  assign w_gnt     = w_arb_gnt;
  assign w_win     = w_arb_idx;

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_acc)
      w_ptr_nxt = (w_win == IW'(NREQ-1)) ? '0
                                         : w_win + 1'b1;
  end
`endif

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req (w_arb_req),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  assign w_acc   = |w_gnt;
  assign w_we    = req_we[w_win];
  assign w_addr  = req_addr[int'(w_win)*AW +: AW];
  assign w_wdata = req_wdata[int'(w_win)*WIDTH +: WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      SWEEP: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == AW'(DEPTH-1))
          w_state_nxt = SERVE;
      end
      SERVE: begin
        if (clr_i)
          w_state_nxt = SWEEP;
      end
      default: w_state_nxt = SWEEP;
    endcase
  end

  always_ff @(posedge __clk or negedge __arst_n) begin
    if (!__arst_n) begin
      r_state <= SWEEP;
      r_idx   <= '0;
      r_ptr   <= PTR_RST;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_ff @(posedge __clk or negedge __arst_n) begin
    if (!__arst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (r_state == SWEEP) begin
      r_mem[r_idx] <= __reset_value;
    end else if (w_acc && w_we) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  // Read data is the pre-edge entry value; a same-edge write lands after.
  always_ff @(posedge __clk or negedge __arst_n) begin
    if (!__arst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_acc && !w_we;
      if (w_acc && !w_we) begin
        r_rsp_id    <= w_win;
        r_rsp_rdata <= r_mem[w_addr];
      end
    end
  end

  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_rdata = r_rsp_rdata;
  assign busy_o    = (r_state == SWEEP);

endmodule

// File: tb/tb_reg_bank_sched.sv
// Self-checking bench for reg_bank_sched: vector table, directed corners,
// and random traffic against a behavioural model of the bank.
module tb_reg_bank_sched;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic [WIDTH-1:0]  reset_value;
  logic              clr;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              busy_o;

  reg_bank_sched #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .DEPTH (DEPTH)
  ) dut (
    .__clk         (clk),
    .__arst_n      (arst_n),
    .__reset_value (reset_value),
    .clr_i         (clr),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_rdata     (rsp_rdata),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: sweep counter, entry array, pointer, pending response.
  int              m_sweep;
  logic [15:0]     m_mem [DEPTH];
  int              m_ptr;
  bit              m_rv;
  int              m_rid;
  logic [15:0]     m_rd;
  logic            tb_busy;
  logic [3:0]      tb_rdy;

  task automatic model_reset();
    m_sweep = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
`ifdef REG_BANK_SCHED_PRIO_EN
    m_ptr = 1;
`else
    m_ptr = 0;
`endif
    m_rv = 0;
    m_rid = 0;
    m_rd = '0;
  endtask

  function automatic int m_winner();
    int r;
    if (m_sweep > 0 || clr) return -1;
`ifdef REG_BANK_SCHED_PRIO_EN
    if (req_valid[0]) return 0;
    for (int k = 0; k < NREQ-1; k++) begin
      r = 1 + ((m_ptr - 1 + k) % (NREQ-1));
      if (req_valid[r]) return r;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      r = (m_ptr + k) % NREQ;
      if (req_valid[r]) return r;
    end
`endif
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  we;
    logic [11:0] addr;
    logic [63:0] wd;
    logic [3:0]  er;
    logic        erv;
    logic [1:0]  eid;
    logic [15:0] ed;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(logic [3:0] v, logic [3:0] we,
                              logic [11:0] addr, logic [63:0] wd,
                              logic [3:0] er, logic erv,
                              logic [1:0] eid, logic [15:0] ed);
    vec_t t;
    t.v = v; t.we = we; t.addr = addr; t.wd = wd;
    t.er = er; t.erv = erv; t.eid = eid; t.ed = ed;
    return t;
  endfunction

  // One clock: check at negedge, advance model at posedge, return at +1.
  task automatic step(input int row);
    int w;
    logic [3:0] er;
    logic [2:0] a;
    @(negedge clk);
    w = m_winner();
    er = (w < 0) ? 4'b0 : 4'(1 << w);
    chk("req_ready", req_ready, er);
    chk("busy_o", busy_o, m_sweep > 0);
    chk("rsp_valid", rsp_valid, m_rv);
    if (m_rv) begin
      chk("rsp_id", rsp_id, m_rid);
      chk("rsp_rdata", rsp_rdata, m_rd);
    end
    tb_busy = busy_o;
    tb_rdy = req_ready;
    if (row >= 0) begin
      chk("tbl_ready", req_ready, tbl[row].er);
      chk("tbl_rsp_valid", rsp_valid, tbl[row].erv);
      if (tbl[row].erv) begin
        chk("tbl_rsp_id", rsp_id, tbl[row].eid);
        chk("tbl_rsp_rdata", rsp_rdata, tbl[row].ed);
      end
    end
    @(posedge clk);
    if (m_sweep > 0) begin
      m_mem[DEPTH - m_sweep] = reset_value;
      m_sweep--;
      m_rv = 0;
    end else if (clr) begin
      m_sweep = DEPTH;
      m_rv = 0;
    end else if (w >= 0) begin
      a = req_addr[w*AW +: AW];
      m_rv = !req_we[w];
      if (!req_we[w]) begin
        m_rid = w;
        m_rd = m_mem[a];
      end else begin
        m_mem[a] = req_wdata[w*WIDTH +: WIDTH];
      end
`ifdef REG_BANK_SCHED_PRIO_EN
      if (w != 0) m_ptr = (w % (NREQ-1)) + 1;
`else
      m_ptr = (w + 1) % NREQ;
`endif
    end else begin
      m_rv = 0;
    end
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we = '0;
    clr = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [3:0] rdy_or;

    tbl[0]  = mk(4'hF, 4'h0, 12'h688, 64'h0, 4'h1, 1'b0, 2'd0, 16'h0);
    tbl[1]  = mk(4'hF, 4'h0, 12'h688, 64'h0, 4'h2, 1'b1, 2'd0, 16'hA5A5);
    tbl[2]  = mk(4'hF, 4'h0, 12'h688, 64'h0, 4'h4, 1'b1, 2'd1, 16'hA5A5);
    tbl[3]  = mk(4'hF, 4'h0, 12'h688, 64'h0, 4'h8, 1'b1, 2'd2, 16'hA5A5);
    tbl[4]  = mk(4'hF, 4'h0, 12'h688, 64'h0, 4'h1, 1'b1, 2'd3, 16'hA5A5);
    tbl[5]  = mk(4'h2, 4'h2, 12'h018, 64'h12340000,
                 4'h2, 1'b1, 2'd0, 16'hA5A5);
    tbl[6]  = mk(4'h4, 4'h0, 12'h0C0, 64'h0, 4'h4, 1'b0, 2'd0, 16'h0);
    tbl[7]  = mk(4'h0, 4'h0, 12'h000, 64'h0, 4'h0, 1'b1, 2'd2, 16'h1234);
    tbl[8]  = mk(4'h8, 4'h0, 12'hE00, 64'h0, 4'h8, 1'b0, 2'd0, 16'h0);
    tbl[9]  = mk(4'h8, 4'h0, 12'h600, 64'h0, 4'h8, 1'b1, 2'd3, 16'hA5A5);
    tbl[10] = mk(4'h9, 4'h0, 12'h605, 64'h0, 4'h1, 1'b1, 2'd3, 16'h1234);
    tbl[11] = mk(4'h0, 4'h0, 12'h000, 64'h0, 4'h0, 1'b1, 2'd0, 16'hA5A5);

    reset_value = 16'hA5A5;
    clr = 1'b0;
    req_valid = 4'hF;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;

    #12;
    chk("rst_req_ready", req_ready, 4'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0);
    chk("rst_busy", busy_o, 1'b1);

    model_reset();
    idle();
    @(posedge clk);
    #1 arst_n = 1'b1;

    cnt = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(-1);
      cnt += int'(tb_busy);
    end
    chk("busy_cycles_after_reset", cnt, DEPTH);

    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].v;
      req_we = tbl[i].we;
      req_addr = tbl[i].addr;
      req_wdata = tbl[i].wd;
`ifdef REG_BANK_SCHED_PRIO_EN
      step(-1);
`else
      step(i);
`endif
    end

    // clr while requester 0 is valid, plus an ignored mid-sweep clr.
    reset_value = 16'h5A3C;
    req_valid = 4'h1;
    req_we = '0;
    req_addr = '0;
    clr = 1'b1;
    step(-1);
    chk("clr_cycle_ready", tb_rdy, 4'h0);
    cnt = 0;
    rdy_or = '0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      clr = (i == 3);
      step(-1);
      cnt += int'(tb_busy);
      if (i < DEPTH) rdy_or |= tb_rdy;
    end
    chk("busy_cycles_after_clr", cnt, DEPTH);
    chk("ready_during_sweep", rdy_or, 4'h0);
    clr = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      req_valid = 4'h1;
      req_addr = 12'(a);
      step(-1);
    end
    idle();
    step(-1);
    chk("sweep_value", rsp_rdata, 16'h5A3C);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      req_valid = 4'($urandom);
      req_we = 4'($urandom);
      req_addr = 12'($urandom);
      req_wdata = {$urandom, $urandom};
      clr = ($urandom_range(0, 49) == 0);
      if (clr) reset_value = 16'($urandom);
      step(-1);
    end

    // Reset arrives while a read is granted, before its edge.
    idle();
    for (int i = 0; i < 20 && m_sweep > 0; i++) step(-1);
    chk("serve_reached", m_sweep, 0);
    step(-1);
    req_valid = 4'h1;
    req_addr = 12'h002;
    @(negedge clk);
    chk("pre_reset_ready", req_ready, 4'h1);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 4'h0);
    chk("arst_busy", busy_o, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 chk("arst_no_rsp", rsp_valid, 1'b0);
    end

    // Reset arrives while a response is showing.
    model_reset();
    reset_value = 16'h0F0F;
    idle();
    arst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(-1);
    req_valid = 4'h4;
    req_addr = 12'h1C0;
    step(-1);
    idle();
    chk("rsp_before_reset", rsp_valid, 1'b1);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_rsp_id", rsp_id, 2'd0);
    chk("arst_rsp_rdata", rsp_rdata, 16'h0);
    chk("arst_busy2", busy_o, 1'b1);
    model_reset();
    @(posedge clk);
    #1 arst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(-1);
      cnt += int'(tb_busy);
    end
    chk("busy_cycles_rereset", cnt, DEPTH);
    req_valid = 4'h1;
    req_addr = 12'h007;
    step(-1);
    idle();
    step(-1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
